// File: rtl/croc_sram_bank_arb.sv
// Round-robin share of one single-port SRAM bank between NumMgr OBI
// managers; fixed 1-cycle response and a saturating contention counter.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   mgr_*_i / mgr_gnt_o    per-manager OBI request channel (flattened)
//   mgr_rvalid_o           one-hot response valid
//   mgr_rdata/rid/err_o    shared response payload
//   sram_*                 bank access strobe, payload and read data
//   cnt_clr_i, cnt_o       contention counter clear and value
module croc_sram_bank_arb #(
  parameter int unsigned NumMgr        = 3,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IdWidth       = 1,
  parameter int unsigned BankAddrWidth = 9,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumMgr-1:0]              mgr_req_i,
  input  logic [NumMgr-1:0]              mgr_we_i,
  input  logic [NumMgr*32-1:0]           mgr_addr_i,
  input  logic [NumMgr*DataWidth/8-1:0]  mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]    mgr_wdata_i,
  input  logic [NumMgr*IdWidth-1:0]      mgr_aid_i,
  output logic [NumMgr-1:0]              mgr_gnt_o,
  output logic [NumMgr-1:0]              mgr_rvalid_o,
  output logic [DataWidth-1:0]           mgr_rdata_o,
  output logic [IdWidth-1:0]             mgr_rid_o,
  output logic                           mgr_err_o,
  output logic                           sram_req_o,
  output logic                           sram_we_o,
  output logic [BankAddrWidth-1:0]       sram_addr_o,
  output logic [DataWidth/8-1:0]         sram_be_o,
  output logic [DataWidth-1:0]           sram_wdata_o,
  input  logic [DataWidth-1:0]           sram_rdata_i,
  input  logic                           cnt_clr_i,
  output logic [CntWidth-1:0]            cnt_o
);

  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned PtrW = $clog2(NumMgr);

  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                resp_valid_q;
  logic [PtrW-1:0]     resp_idx_q;
  logic                resp_we_q;
  logic [IdWidth-1:0]  rid_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  logic            found;
  logic [PtrW-1:0] sel;
  int              k;
  int              s;
  int              nreq;
  logic            contended;

  // Scan from the pointer, wrapping, and take the first requester.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    k     = 0;
    for (int i = 0; i < int'(NumMgr); i++) begin
      k = (int'(rr_ptr_q) + i) % int'(NumMgr);
      if (!found && mgr_req_i[k]) begin
        found = 1'b1;
        sel   = PtrW'(k);
      end
    end
  end

  assign s = int'(sel);

  always_comb begin
    mgr_gnt_o    = '0;
    sram_req_o   = found;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    if (found) begin
      mgr_gnt_o    = NumMgr'(1) << sel;
      sram_we_o    = mgr_we_i[s];
      sram_addr_o  = mgr_addr_i[s*32+2 +: BankAddrWidth];
      sram_be_o    = mgr_be_i[s*BeW +: BeW];
      sram_wdata_o = mgr_wdata_i[s*DataWidth +: DataWidth];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      if (sel == PtrW'(NumMgr - 1)) rr_ptr_d = '0;
      else                          rr_ptr_d = sel + 1'b1;
    end
  end

  always_comb begin
    nreq = 0;
    for (int i = 0; i < int'(NumMgr); i++) begin
      nreq = nreq + int'(mgr_req_i[i]);
    end
  end

  assign contended = (nreq >= 2);

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                   cnt_d = '0;
    else if (contended && ~&cnt_q)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      resp_we_q    <= 1'b0;
      rid_q        <= '0;
      cnt_q        <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= found;
      if (found) begin
        resp_idx_q <= sel;
        resp_we_q  <= mgr_we_i[s];
        rid_q      <= mgr_aid_i[s*IdWidth +: IdWidth];
      end
      cnt_q        <= cnt_d;
    end
  end

  assign mgr_rvalid_o = resp_valid_q ? (NumMgr'(1) << resp_idx_q) : '0;
  assign mgr_rdata_o  = (resp_valid_q && !resp_we_q) ? sram_rdata_i : '0;
  assign mgr_rid_o    = resp_valid_q ? rid_q : '0;
  assign mgr_err_o    = 1'b0;
  assign cnt_o        = cnt_q;

  // Upper address bits select the bank upstream; only the word index matters.
  logic unused_addr;
  assign unused_addr = ^mgr_addr_i;

endmodule

// File: tb/tb_croc_sram_bank_arb.sv
// Directed bench for croc_sram_bank_arb with a behavioural SRAM model.
// Counter width is reduced to 4 bits to reach saturation quickly.
module tb_croc_sram_bank_arb;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int AW = 9;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, we;
  logic [N*32-1:0] addr;
  logic [N*4-1:0]  be;
  logic [N*DW-1:0] wdata;
  logic [N*IW-1:0] aid;
  logic [N-1:0]    gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic [IW-1:0]   rid;
  logic            err;
  logic            s_req, s_we;
  logic [AW-1:0]   s_addr;
  logic [3:0]      s_be;
  logic [DW-1:0]   s_wdata;
  logic [DW-1:0]   s_rdata;
  logic            clr;
  logic [CW-1:0]   cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [512];

  always #5 clk = ~clk;

  croc_sram_bank_arb #(
    .NumMgr(N), .DataWidth(DW), .IdWidth(IW),
    .BankAddrWidth(AW), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mgr_req_i(req), .mgr_we_i(we), .mgr_addr_i(addr),
    .mgr_be_i(be), .mgr_wdata_i(wdata), .mgr_aid_i(aid),
    .mgr_gnt_o(gnt), .mgr_rvalid_o(rvalid), .mgr_rdata_o(rdata),
    .mgr_rid_o(rid), .mgr_err_o(err),
    .sram_req_o(s_req), .sram_we_o(s_we), .sram_addr_o(s_addr),
    .sram_be_o(s_be), .sram_wdata_o(s_wdata), .sram_rdata_i(s_rdata),
    .cnt_clr_i(clr), .cnt_o(cnt)
  );

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hA500_0000 | i;
    s_rdata = '0;
  end

  always @(posedge clk) begin
    if (s_req) begin
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_be[b]) mem[s_addr][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
      s_rdata <= mem[s_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_mgr(input int i, input logic w, input logic [31:0] a,
                         input logic [3:0] e, input logic [31:0] d,
                         input logic id);
    we[i]          = w;
    addr[i*32 +: 32] = a;
    be[i*4 +: 4]   = e;
    wdata[i*32 +: 32] = d;
    aid[i]         = id;
  endtask

  task automatic clear_all();
    req = '0; we = '0; addr = '0; be = '0; wdata = '0; aid = '0;
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_all();
    clr   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_sreq", 32'(s_req), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", 32'(rid), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single read from manager 0
    @(negedge clk);
    set_mgr(0, 1'b0, 32'h1000_0010, 4'hF, 32'h0, 1'b1);
    req = 3'b001;
    #1;
    chk("rd_gnt", 32'(gnt), 32'b001);
    chk("rd_sreq", 32'(s_req), 1);
    chk("rd_saddr", 32'(s_addr), 4);
    chk("rd_swe", 32'(s_we), 0);
    @(posedge clk); #1;
    chk("rd_rvalid", 32'(rvalid), 32'b001);
    chk("rd_rdata", rdata, 32'hA500_0004);
    chk("rd_rid", 32'(rid), 1);

    // write from manager 2, then read it back
    @(negedge clk);
    clear_all();
    set_mgr(2, 1'b1, 32'h0000_0008, 4'hF, 32'hDEAD_BEEF, 1'b0);
    req = 3'b100;
    #1;
    chk("wr_gnt", 32'(gnt), 32'b100);
    chk("wr_swdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr_saddr", 32'(s_addr), 2);
    chk("wr_swe", 32'(s_we), 1);
    @(posedge clk); #1;
    chk("wr_rvalid", 32'(rvalid), 32'b100);
    chk("wr_rdata", rdata, 0);
    @(negedge clk);
    we[2] = 1'b0;
    @(posedge clk); #1;
    chk("rb_rvalid", 32'(rvalid), 32'b100);
    chk("rb_rdata", rdata, 32'hDEAD_BEEF);

    // fairness from reset
    @(negedge clk);
    clear_all();
    rst_pulse();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req = 3'b111;
      #1;
      chk("fair_gnt", 32'(gnt), 32'(1 << (i % 3)));
      @(posedge clk); #1;
      chk("fair_rvalid", 32'(rvalid), 32'(1 << (i % 3)));
    end
    @(negedge clk);
    req = '0;
    #1;
    chk("fair_cnt", 32'(cnt), 6);

    // pointer skip: bring pointer to 1, then only manager 0 asks
    @(negedge clk);
    req = 3'b001;
    @(negedge clk);
    req = 3'b001;
    #1;
    chk("skip_gnt0", 32'(gnt), 32'b001);
    @(negedge clk);
    req = 3'b101;
    #1;
    chk("skip_gnt2", 32'(gnt), 32'b100);
    @(negedge clk);
    req = '0;
    #1;
    chk("skip_cnt", 32'(cnt), 7);

    // counter clear, saturation, clear during contention
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr_idle", 32'(cnt), 0);
    req = 3'b011;
    repeat (20) @(posedge clk);
    @(negedge clk);
    req = '0;
    #1;
    chk("cnt_sat", 32'(cnt), 15);
    @(negedge clk);
    req = 3'b111;
    clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_busy", 32'(cnt), 0);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    chk("cnt_after_clr", 32'(cnt), 1);

    // reset between grant and response
    @(negedge clk);
    clear_all();
    rst_pulse();
    @(negedge clk);
    set_mgr(1, 1'b0, 32'h0000_0020, 4'hF, 32'h0, 1'b1);
    req = 3'b010;
    @(negedge clk);
    req = 3'b010;
    @(posedge clk); #1;
    chk("pre_rst_rvalid", 32'(rvalid), 32'b010);
    req = '0;
    rst_n = 1'b0;
    #1;
    chk("arst_rvalid", 32'(rvalid), 0);
    chk("arst_rid", 32'(rid), 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_sreq", 32'(s_req), 0);
    chk("arst_cnt", 32'(cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rvalid", 32'(rvalid), 0);
    @(negedge clk);
    req = 3'b110;
    #1;
    chk("post_rst_gnt", 32'(gnt), 32'b010);
    @(negedge clk);
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
